// File: rtl/ins_fetch_dispatch.sv
// Instruction fetch/dispatch sequencer: reads the program from instruction RAM,
// hands each compute instruction to its unit and signals completion.
module ins_fetch_dispatch #(
    parameter int INS_W   = 512,
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ins_ram_en,
    output logic [ADDR_W-1:0] ins_ram_addr,
    input  logic [INS_W-1:0]  ins_ram_dout,
    output logic [INS_W-1:0]  ins,
    output logic              conv_valid,
    input  logic              conv_ready,
    output logic              add_valid,
    input  logic              add_ready,
    output logic              remap_valid,
    input  logic              remap_ready,
    input  logic [2:0]        unit_busy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_pc,
    output logic [31:0]       n_disp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DISP,
        S_DRAIN
    } state_t;

    localparam logic [7:0]        OP_END   = 8'h00;
    localparam logic [7:0]        OP_CONV  = 8'h01;
    localparam logic [7:0]        OP_ADD   = 8'h02;
    localparam logic [7:0]        OP_REMAP = 8'h03;
    localparam logic [2:0]        LAT_INIT = 3'(RAM_LAT - 1);
    localparam logic [ADDR_W-1:0] PC_MAX   = '1;
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [2:0]          r_lat;
    logic                r_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [INS_W-1:0]    r_ins;
    logic                r_conv_vld;
    logic                r_add_vld;
    logic                r_remap_vld;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_pc;
    logic [31:0]         r_n_disp;

    logic [7:0]          w_op;
    logic                w_hs;
    logic                w_vld_any;

    assign w_op      = ins_ram_dout[7:0];
    // Only the selected unit's ready matters; the others never have valid set.
    assign w_hs      = (r_conv_vld & conv_ready) | (r_add_vld & add_ready)
                     | (r_remap_vld & remap_ready);
    assign w_vld_any = r_conv_vld | r_add_vld | r_remap_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_lat       <= '0;
            r_en        <= 1'b0;
            r_addr      <= '0;
            r_ins       <= '0;
            r_conv_vld  <= 1'b0;
            r_add_vld   <= 1'b0;
            r_remap_vld <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_pc    <= '0;
            r_n_disp    <= '0;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err    <= 1'b0;
                        r_err_pc <= '0;
                        r_n_disp <= '0;
                        r_pc     <= '0;
                        r_addr   <= '0;
                        r_en     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_lat   <= LAT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat != 3'd0) begin
                        r_lat <= r_lat - 3'd1;
                    end else begin
                        r_ins <= ins_ram_dout;
                        case (w_op)
                            OP_END:   r_state <= S_DRAIN;
                            OP_CONV:  begin r_conv_vld  <= 1'b1; r_state <= S_DISP; end
                            OP_ADD:   begin r_add_vld   <= 1'b1; r_state <= S_DISP; end
                            OP_REMAP: begin r_remap_vld <= 1'b1; r_state <= S_DISP; end
                            default: begin
                                r_err    <= 1'b1;
                                r_err_pc <= r_pc;
                                r_state  <= S_DRAIN;
                            end
                        endcase
                    end
                end
                S_DISP: begin
                    if (w_hs) begin
                        r_conv_vld  <= 1'b0;
                        r_add_vld   <= 1'b0;
                        r_remap_vld <= 1'b0;
                        if (r_n_disp != 32'hFFFF_FFFF)
                            r_n_disp <= r_n_disp + 32'd1;
                        // The program ran off the end of RAM without an End.
                        if (r_pc == PC_MAX) begin
                            r_err    <= 1'b1;
                            r_err_pc <= r_pc;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_addr  <= r_pc + PC_ONE;
                            r_en    <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (unit_busy == 3'b000 && !w_vld_any) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ins_ram_en   = r_en;
    assign ins_ram_addr = r_addr;
    assign ins          = r_ins;
    assign conv_valid   = r_conv_vld;
    assign add_valid    = r_add_vld;
    assign remap_valid  = r_remap_vld;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign err_pc       = r_err_pc;
    assign n_disp       = r_n_disp;

endmodule

// File: tb/tb_ins_fetch_dispatch.sv
// Bench for ins_fetch_dispatch: per-run timeline model built from the program,
// ready and busy patterns, compared against the DUT every cycle.
module tb_ins_fetch_dispatch;

    localparam int INS_W   = 64;
    localparam int ADDR_W  = 3;
    localparam int RAM_LAT = 2;
    localparam int DEPTH   = 8;
    localparam int MAXC    = 256;

    logic              clk;
    logic              rst;
    logic              start;
    logic              ins_ram_en;
    logic [ADDR_W-1:0] ins_ram_addr;
    logic [INS_W-1:0]  ins_ram_dout;
    logic [INS_W-1:0]  ins;
    logic              conv_valid, conv_ready;
    logic              add_valid, add_ready;
    logic              remap_valid, remap_ready;
    logic [2:0]        unit_busy;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_pc;
    logic [31:0]       n_disp;

    ins_fetch_dispatch #(.INS_W(INS_W), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ins_ram_en(ins_ram_en), .ins_ram_addr(ins_ram_addr), .ins_ram_dout(ins_ram_dout),
        .ins(ins),
        .conv_valid(conv_valid), .conv_ready(conv_ready),
        .add_valid(add_valid), .add_ready(add_ready),
        .remap_valid(remap_valid), .remap_ready(remap_ready),
        .unit_busy(unit_busy), .busy(busy), .done(done), .err(err),
        .err_pc(err_pc), .n_disp(n_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory and per-cycle stimulus of the current run
    logic [63:0] prog    [DEPTH];
    logic [2:0]  rdy_t   [MAXC];
    logic [2:0]  ub_t    [MAXC];
    logic        start_t [MAXC];

    // Expected outputs, indexed by cycle within the run (0 = start cycle)
    logic              e_en    [MAXC];
    logic [ADDR_W-1:0] e_addr  [MAXC];
    logic [2:0]        e_vld   [MAXC];
    logic [63:0]       e_ins   [MAXC];
    logic              e_busy  [MAXC];
    logic              e_done  [MAXC];
    logic              e_err   [MAXC];
    logic [ADDR_W-1:0] e_errpc [MAXC];
    logic [31:0]       e_nd    [MAXC];

    // State carried from the end of the previous run
    logic [63:0]       p_ins;
    logic              p_err;
    logic [ADDR_W-1:0] p_errpc;
    logic [31:0]       p_nd;

    int cur_k;
    bit run_active;
    int run_len, done_k;
    int n_checks, n_errors;
    int obs_done_cnt, obs_done_k;
    int obs_vld_cnt [3];
    int obs_vld_first [3];

    // Instruction RAM with RAM_LAT cycles of read latency; garbage when not valid
    logic [ADDR_W-1:0] ra_pipe [RAM_LAT];
    logic              rv_pipe [RAM_LAT];
    logic [63:0]       junk;
    always @(posedge clk) begin
        ra_pipe[0] <= ins_ram_addr;
        rv_pipe[0] <= ins_ram_en;
        for (int i = 1; i < RAM_LAT; i++) begin
            ra_pipe[i] <= ra_pipe[i-1];
            rv_pipe[i] <= rv_pipe[i-1];
        end
        junk <= {$urandom, $urandom};
    end
    assign ins_ram_dout = (rv_pipe[RAM_LAT-1] === 1'b1) ? prog[ra_pipe[RAM_LAT-1]] : junk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cur_k, act, exp);
        end
    endtask

    // Timeline model: each instruction is fetched, appears RAM_LAT+1 cycles later,
    // and (if compute) is held until its unit is ready; drain ends on idle units.
    task automatic build_model(input int kr);
        int t, v, h, e, kz, pc, nd;
        logic [7:0] op;
        logic [2:0] sel;
        bit stop;
        for (int k = 0; k < MAXC; k++) begin
            e_en[k]    = 1'b0;
            e_addr[k]  = '0;
            e_vld[k]   = 3'b000;
            e_ins[k]   = p_ins;
            e_busy[k]  = (k >= 1);
            e_done[k]  = 1'b0;
            e_err[k]   = (k == 0) ? p_err : 1'b0;
            e_errpc[k] = (k == 0) ? p_errpc : '0;
            e_nd[k]    = (k == 0) ? p_nd : 32'd0;
        end
        t = 1; pc = 0; nd = 0; e = 0; stop = 0;
        while (!stop) begin
            e_en[t]   = 1'b1;
            e_addr[t] = ADDR_W'(pc);
            v  = t + RAM_LAT + 1;
            op = prog[pc][7:0];
            for (int k = v; k < MAXC; k++) e_ins[k] = prog[pc];
            if (op == 8'h00) begin
                e = v; stop = 1;
            end else if (op > 8'h03) begin
                e = v; stop = 1;
                for (int k = v; k < MAXC; k++) begin e_err[k] = 1'b1; e_errpc[k] = ADDR_W'(pc); end
            end else begin
                sel = (op == 8'h01) ? 3'b001 : (op == 8'h02) ? 3'b010 : 3'b100;
                h = v;
                while (h < MAXC - 1 && (rdy_t[h] & sel) == 3'b000) h++;
                for (int k = v; k <= h; k++) e_vld[k] = sel;
                nd++;
                for (int k = h + 1; k < MAXC; k++) e_nd[k] = 32'(nd);
                if (pc == DEPTH - 1) begin
                    e = h + 1; stop = 1;
                    for (int k = h + 1; k < MAXC; k++) begin e_err[k] = 1'b1; e_errpc[k] = ADDR_W'(pc); end
                end else begin
                    pc++;
                    t = h + 1;
                end
            end
        end
        kz = e;
        while (kz < MAXC - 2 && ub_t[kz] != 3'b000) kz++;
        done_k = kz + 1;
        e_done[done_k] = 1'b1;
        for (int k = done_k; k < MAXC; k++) e_busy[k] = 1'b0;
        run_len = done_k + 3;
        if (kr >= 0) begin
            for (int k = kr + 1; k < MAXC; k++) begin
                e_en[k] = 1'b0; e_addr[k] = '0; e_vld[k] = 3'b000; e_ins[k] = '0;
                e_busy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0; e_errpc[k] = '0; e_nd[k] = 32'd0;
            end
            run_len = kr + 3;
        end
    endtask

    always @(negedge clk) begin
        if (run_active) begin
            check("ins_ram_en", 64'(ins_ram_en), 64'(e_en[cur_k]));
            if (e_en[cur_k]) check("ins_ram_addr", 64'(ins_ram_addr), 64'(e_addr[cur_k]));
            check("valids", 64'({remap_valid, add_valid, conv_valid}), 64'(e_vld[cur_k]));
            check("ins", ins, e_ins[cur_k]);
            check("busy", 64'(busy), 64'(e_busy[cur_k]));
            check("done", 64'(done), 64'(e_done[cur_k]));
            check("err", 64'(err), 64'(e_err[cur_k]));
            check("err_pc", 64'(err_pc), 64'(e_errpc[cur_k]));
            check("n_disp", 64'(n_disp), 64'(e_nd[cur_k]));
            if (done === 1'b1) begin obs_done_cnt++; obs_done_k = cur_k; end
            if (conv_valid === 1'b1)  begin if (obs_vld_first[0] < 0) obs_vld_first[0] = cur_k; obs_vld_cnt[0]++; end
            if (add_valid === 1'b1)   begin if (obs_vld_first[1] < 0) obs_vld_first[1] = cur_k; obs_vld_cnt[1]++; end
            if (remap_valid === 1'b1) begin if (obs_vld_first[2] < 0) obs_vld_first[2] = cur_k; obs_vld_cnt[2]++; end
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < DEPTH; i++) prog[i] = {$urandom, 24'($urandom), 8'h00};
        for (int k = 0; k < MAXC; k++) begin rdy_t[k] = 3'b111; ub_t[k] = 3'b000; end
    endtask

    task automatic set_op(input int a, input logic [7:0] op);
        prog[a][7:0] = op;
    endtask

    task automatic gen_random();
        int len, r;
        logic [7:0] op;
        len = $urandom_range(1, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            r  = $urandom_range(0, 19);
            op = (r == 0) ? 8'($urandom_range(4, 255)) : (r < 3) ? 8'h00 : 8'($urandom_range(1, 3));
            prog[i] = {$urandom, 24'($urandom), op};
        end
        if (len < DEPTH) prog[len-1][7:0] = 8'h00;
        for (int k = 0; k < MAXC; k++) begin
            rdy_t[k] = (k < 150) ? 3'($urandom) : 3'b111;
            ub_t[k]  = (k < 150 && $urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        end
    endtask

    // kr: cycle to pulse rst (-1 none, -2 pick randomly); spurious: stray starts mid-run
    task automatic do_run(input int kr, input bit spurious);
        int rk, lim;
        rk = kr;
        build_model(-1);
        if (rk == -2) rk = ($urandom_range(0, 7) == 0) ? $urandom_range(1, done_k - 1) : -1;
        if (rk >= 0) build_model(rk);
        lim = (rk >= 0) ? rk + 1 : done_k;
        for (int k = 0; k < MAXC; k++) start_t[k] = 1'b0;
        start_t[0] = 1'b1;
        if (spurious) for (int k = 1; k < lim; k++) start_t[k] = ($urandom_range(0, 15) == 0);
        obs_done_cnt = 0; obs_done_k = -1;
        for (int u = 0; u < 3; u++) begin obs_vld_cnt[u] = 0; obs_vld_first[u] = -1; end
        for (int k = 0; k < run_len; k++) begin
            @(posedge clk);
            #1;
            cur_k = k;
            run_active = 1'b1;
            start = start_t[k];
            {remap_ready, add_ready, conv_ready} = rdy_t[k];
            unit_busy = ub_t[k];
            rst = (k == rk);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        p_ins   = e_ins[run_len-1];
        p_err   = e_err[run_len-1];
        p_errpc = e_errpc[run_len-1];
        p_nd    = e_nd[run_len-1];
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cur_k = 0; run_active = 1'b0;
        p_ins = '0; p_err = 1'b0; p_errpc = '0; p_nd = 32'd0;
        rst = 1'b1; start = 1'b0; conv_ready = 1'b0; add_ready = 1'b0; remap_ready = 1'b0;
        unit_busy = 3'b000;
        clear_stim();
        repeat (3) @(posedge clk);
        #1;
        check("reset en", 64'(ins_ram_en), 64'd0);
        check("reset valids", 64'({remap_valid, add_valid, conv_valid}), 64'd0);
        check("reset busy/done/err", 64'({busy, done, err}), 64'd0);
        check("reset n_disp", 64'(n_disp), 64'd0);
        check("reset ins", ins, 64'd0);
        rst = 1'b0;

        // Conv, Add, Remap, End with everything ready
        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h02); set_op(2, 8'h03); set_op(3, 8'h00);
        do_run(-1, 1'b0);
        check("A first conv", 64'(obs_vld_first[0]), 64'd4);
        check("A first add", 64'(obs_vld_first[1]), 64'd8);
        check("A first remap", 64'(obs_vld_first[2]), 64'd12);
        check("A done cycle", 64'(obs_done_k), 64'd17);
        check("A n_disp", 64'(n_disp), 64'd3);

        // Conv stalled by ready low for 5 cycles
        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h00);
        for (int k = 4; k <= 8; k++) rdy_t[k][0] = 1'b0;
        do_run(-1, 1'b0);
        check("B conv valid cycles", 64'(obs_vld_cnt[0]), 64'd6);
        check("B done cycle", 64'(obs_done_k), 64'd14);

        // End reached while conv unit still busy for 20 cycles
        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h00);
        for (int k = 5; k <= 27; k++) ub_t[k] = 3'b001;
        do_run(-1, 1'b0);
        check("C done cycle", 64'(obs_done_k), 64'd29);

        // Illegal opcode at address 2
        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h02); set_op(2, 8'h07); set_op(3, 8'h00);
        do_run(-1, 1'b0);
        check("D err", 64'(err), 64'd1);
        check("D err_pc", 64'(err_pc), 64'd2);
        check("D n_disp", 64'(n_disp), 64'd2);
        check("D done cycle", 64'(obs_done_k), 64'd13);

        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h02); set_op(2, 8'h03); set_op(3, 8'h00);
        do_run(-1, 1'b0);
        check("D2 err cleared", 64'(err), 64'd0);

        // Reset while Conv is waiting for ready
        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h00);
        for (int k = 0; k < 20; k++) rdy_t[k] = 3'b000;
        do_run(5, 1'b0);
        check("E conv valid cycles", 64'(obs_vld_cnt[0]), 64'd2);
        check("E no done", 64'(obs_done_cnt), 64'd0);

        clear_stim();
        set_op(0, 8'h01); set_op(1, 8'h02); set_op(2, 8'h03); set_op(3, 8'h00);
        do_run(-1, 1'b0);
        check("E2 done cycle", 64'(obs_done_k), 64'd17);

        // No End: runs off the top of the address space
        clear_stim();
        for (int i = 0; i < DEPTH; i++) set_op(i, 8'h02);
        do_run(-1, 1'b0);
        check("F err", 64'(err), 64'd1);
        check("F err_pc", 64'(err_pc), 64'd7);
        check("F n_disp", 64'(n_disp), 64'd8);
        check("F done cycle", 64'(obs_done_k), 64'd34);

        for (int r = 0; r < 40; r++) begin
            gen_random();
            do_run(-2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_dispatch.md
Name: ins_fetch_dispatch

Overview:
- Sequencer that sits between the instruction RAM and the per-opcode execution units (Conv, Add, Remap), feeding their instruction decoders.
- On a start pulse it reads instructions from address 0 and classifies each by opcode field ins[7:0].
- It hands each instruction to the matching unit over a valid/ready handshake, stops at an End instruction, waits for all units to go idle, then pulses done.

Parameters:
- INS_W, 512, instruction word width (equals INS_RAM_DATA_WIDTH).
- ADDR_W, 12, instruction RAM address width; depth = 2^ADDR_W.
- RAM_LAT, 2, instruction RAM read latency in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin execution at address 0.
- ins_ram_en  out  1  RAM read enable.
- ins_ram_addr  out  ADDR_W  RAM read address.
- ins_ram_dout  in  INS_W  RAM read data, valid RAM_LAT cycles after en.
- ins  out  INS_W  registered instruction; one bus shared by all units.
- conv_valid / conv_ready  out / in  1 / 1  Conv dispatch handshake.
- add_valid / add_ready  out / in  1 / 1  Add dispatch handshake.
- remap_valid / remap_ready  out / in  1 / 1  Remap dispatch handshake.
- unit_busy  in  3  {remap, add, conv}; each bit high while that unit executes.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the program completes.
- err  out  1  sticky; set on an illegal opcode or address overflow; cleared by start or rst.
- err_pc  out  ADDR_W  address of the faulting instruction.
- n_disp  out  32  count of instructions dispatched in the current run.

Behaviour:
- Opcodes: 0x00 End, 0x01 Conv, 0x02 Add, 0x03 Remap; any other value is illegal.
- Reset values:
  - All outputs are 0, including ins; pc=0; state IDLE.
  - rst in any state aborts the run immediately. No done pulse is produced and err is cleared.
- States: IDLE, FETCH, WAIT, DISP, DRAIN.
- IDLE:
  - start=1 clears err, err_pc and n_disp, sets pc=0, sets busy=1, and moves to FETCH.
  - start in any other state is ignored.
- FETCH (one cycle): ins_ram_en=1, ins_ram_addr=pc. Go to WAIT with the latency counter = RAM_LAT-1.
- WAIT:
  - Count down. When ins_ram_dout is valid, capture it into ins and decode the opcode.
  - End → DRAIN.
  - Legal compute opcode → DISP.
  - Illegal opcode → err=1, err_pc=pc, then DRAIN; no unit is dispatched.
- DISP:
  - Exactly one of conv/add/remap_valid is high. It is held, with ins stable, until the matching ready is high.
  - Handshake cycle: drop valid next cycle, n_disp+=1, pc+=1, go to FETCH.
  - If pc was 2^ADDR_W-1 at handshake, do not wrap. Set err=1 and err_pc=pc, then go to DRAIN.
- Timing:
  - start high in cycle c → ins_ram_en in c+1 → first valid in c+2+RAM_LAT.
  - Handshake in cycle d → next ins_ram_en in d+1 → next valid in d+2+RAM_LAT.
- Ready before valid is permitted; the handshake occurs on the first cycle both are high. Readies of non-selected units are ignored.
- Units must raise unit_busy no later than the cycle after their handshake.
- DRAIN:
  - Entered on End, illegal opcode or overflow.
  - Waits until unit_busy==0 in the same cycle that no valid is pending.
  - Then done=1 for one cycle, busy=0, state IDLE. If unit_busy is already 0, done is pulsed on the cycle after DRAIN is entered.
- n_disp saturates at 2^32-1. It holds its final value in IDLE until the next start.
- ins holds the last captured instruction while in IDLE.

Test Plan:
- Program [Conv, Add, Remap, End]; all readies tied 1, unit_busy held 0 → valids in that order, n_disp=3, done at the predicted cycle, err=0.
- RAM_LAT=2, start at cycle 10 → ins_ram_en at 11 with addr 0; conv_valid first high at cycle 14.
- Conv with conv_ready low for 5 cycles → conv_valid and ins stable for 6 cycles; pc stays 0 until the handshake.
- End reached while unit_busy=3'b001 for 20 further cycles → done is delayed until 1 cycle after busy clears; busy=1 throughout.
- Opcode 0x07 at address 2 → err=1, err_pc=2, n_disp=2, done pulses; the next start clears err.
- rst asserted during DISP → all valids, busy and done are 0 next cycle; a fresh start re-runs from address 0.
- ADDR_W=2, program with no End (4 Adds) → 4 dispatches, then err=1, err_pc=3, done.
